entropy_collector: RTL and testbench

- Sits downstream of the TRNG register map and consumes the raw ring-oscillator bit stream, one bit per sampling-window strobe.
- Applies a repetition-count health test, Von Neumann debiasing and LSB-first packing into words.
- Buffers the packed words in a small first-word-fall-through FIFO behind a valid/ready interface for the bus-side reader.
- Reports FIFO level, a sticky health alarm and a sticky overflow flag.

---
 rtl/trng_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 69 ++++++
 rtl/entropy_collector.sv | 154 +++++++++++++++
 tb/tb_entropy_collector.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trng_pkg
// Description : Shared types and width helpers for the entropy collector.
// Revision    : 1.0 - initial release
// ============================================================================
package trng_pkg;

    typedef enum logic [0:0] {
        P_IDLE  = 1'b0,
        P_HAVE1 = 1'b1
    } pair_state_t;

    localparam int REP_CNT_W = 8;

    function automatic int lvl_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : First-word-fall-through FIFO with level and full/empty flags.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import trng_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic [WIDTH-1:0]            rd_data,
    output logic                        empty,
    output logic                        full,
    output logic [lvl_width(DEPTH)-1:0] level
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LVL_W  = lvl_width(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic              w_do_pop;
    logic              w_do_push;

    assign empty     = (r_level == '0);
    assign full      = (r_level == LVL_W'(DEPTH));
    assign w_do_pop  = pop & ~empty;
    // A push into a full FIFO still lands when the head is leaving this cycle
    assign w_do_push = push & (~full | w_do_pop);
    assign rd_data   = empty ? '0 : r_mem[r_rd_ptr];
    assign level     = r_level;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_level <= r_level + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/entropy_collector.sv
`default_nettype none
// ============================================================================
// Module      : entropy_collector
// Description : Repetition health test, Von Neumann debiaser and word packer
//               feeding a FWFT FIFO for the bus-side reader.
// Revision    : 1.0 - initial release
// ============================================================================
module entropy_collector
    import trng_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int REP_LIMIT  = 31
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en_i,
    input  logic                             bit_valid_i,
    input  logic                             bit_i,
    input  logic                             clear_i,
    output logic [WORD_WIDTH-1:0]            word_o,
    output logic                             word_valid_o,
    input  logic                             word_ready_i,
    output logic [lvl_width(FIFO_DEPTH)-1:0] level_o,
    output logic                             alarm_o,
    output logic                             overflow_o
);

    localparam int CNT_W = $clog2(WORD_WIDTH);
    localparam logic [REP_CNT_W-1:0] c_rep_limit = REP_CNT_W'(REP_LIMIT);
    localparam logic [CNT_W-1:0]     c_last_pos  = CNT_W'(WORD_WIDTH - 1);

    pair_state_t            r_state;
    logic                   r_first;
    logic                   r_last;
    logic [REP_CNT_W-1:0]   r_rep_cnt;
    logic                   r_alarm;
    logic                   r_overflow;
    logic [CNT_W-1:0]       r_count;
    logic [WORD_WIDTH-1:0]  r_word;

    logic                   w_accept;
    logic [REP_CNT_W-1:0]   w_rep_next;
    logic                   w_emit;
    logic                   w_push;
    logic [WORD_WIDTH-1:0]  w_word;
    logic                   w_fifo_empty;
    logic                   w_fifo_full;
    logic                   w_pop;
    logic                   w_drop;

    assign w_accept = bit_valid_i & en_i & ~r_alarm;

    always_comb begin
        w_rep_next = r_rep_cnt;
        if (r_rep_cnt == '0 || bit_i != r_last) begin
            w_rep_next = REP_CNT_W'(1);
        end else if (r_rep_cnt != c_rep_limit) begin
            w_rep_next = r_rep_cnt + 1'b1;
        end
    end

    // Pairs 01 and 10 emit the first bit of the pair; 00 and 11 emit nothing
    assign w_emit = w_accept & ~clear_i & (r_state == P_HAVE1) & (r_first != bit_i);
    assign w_push = w_emit & (r_count == c_last_pos);

    always_comb begin
        w_word          = r_word;
        w_word[r_count] = r_first;
    end

    assign w_pop        = word_valid_o & word_ready_i;
    assign w_drop       = w_push & w_fifo_full & ~w_pop;
    assign word_valid_o = ~w_fifo_empty;
    assign alarm_o      = r_alarm;
    assign overflow_o   = r_overflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rep_cnt <= '0;
            r_last    <= 1'b0;
            r_alarm   <= 1'b0;
        end else if (clear_i) begin
            r_rep_cnt <= '0;
            r_alarm   <= 1'b0;
        end else if (!en_i) begin
            r_rep_cnt <= '0;
        end else if (w_accept) begin
            r_rep_cnt <= w_rep_next;
            r_last    <= bit_i;
            if (w_rep_next == c_rep_limit) begin
                r_alarm <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (clear_i) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= P_IDLE;
            r_first <= 1'b0;
        end else if (clear_i || !en_i) begin
            r_state <= P_IDLE;
        end else if (w_accept) begin
            case (r_state)
                P_IDLE: begin
                    r_first <= bit_i;
                    r_state <= P_HAVE1;
                end
                default: begin
                    r_state <= P_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_word  <= '0;
        end else if (!en_i) begin
            r_count <= '0;
        end else if (w_emit) begin
            r_word  <= w_word;
            r_count <= w_push ? '0 : r_count + 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_word),
        .pop       (w_pop),
        .rd_data   (word_o),
        .empty     (w_fifo_empty),
        .full      (w_fifo_full),
        .level     (level_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_entropy_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_entropy_collector
// Description : Self-checking bench for entropy_collector with a queue-based
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_entropy_collector;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int RL = 31;
    localparam int LW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          en_i;
    logic          bit_valid_i;
    logic          bit_i;
    logic          clear_i;
    logic [W-1:0]  word_o;
    logic          word_valid_o;
    logic          word_ready_i;
    logic [LW-1:0] level_o;
    logic          alarm_o;
    logic          overflow_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit           m_pend;
    bit           m_first;
    bit           m_bits[$];
    logic [W-1:0] m_fifo[$];
    int           m_rep;
    bit           m_last;
    bit           m_alarm;
    bit           m_ovf;

    entropy_collector #(
        .WORD_WIDTH (W),
        .FIFO_DEPTH (D),
        .REP_LIMIT  (RL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en_i         (en_i),
        .bit_valid_i  (bit_valid_i),
        .bit_i        (bit_i),
        .clear_i      (clear_i),
        .word_o       (word_o),
        .word_valid_o (word_valid_o),
        .word_ready_i (word_ready_i),
        .level_o      (level_o),
        .alarm_o      (alarm_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pend  = 0;
        m_first = 0;
        m_bits.delete();
        m_fifo.delete();
        m_rep   = 0;
        m_last  = 0;
        m_alarm = 0;
        m_ovf   = 0;
    endtask

    // Drive one cycle of inputs, advance the model, then sample after the edge.
    task automatic step(input bit v, input bit b, input bit rdy, input bit e, input bit clr);
        bit           pop;
        bit           have_word;
        int           size0;
        logic [W-1:0] nw;
        bit_valid_i  = v;
        bit_i        = b;
        word_ready_i = rdy;
        en_i         = e;
        clear_i      = clr;
        have_word    = 0;
        nw           = '0;
        size0        = m_fifo.size();
        pop          = rdy && (size0 > 0);
        if (clr) begin
            m_alarm = 0;
            m_ovf   = 0;
            m_rep   = 0;
            m_pend  = 0;
        end
        if (!e) begin
            m_pend = 0;
            m_bits.delete();
            m_rep  = 0;
        end else if (!clr && v && !m_alarm) begin
            if (m_rep == 0 || b != m_last) m_rep = 1;
            else if (m_rep < RL) m_rep++;
            m_last = b;
            if (m_rep == RL) m_alarm = 1;
            if (!m_pend) begin
                m_pend  = 1;
                m_first = b;
            end else begin
                m_pend = 0;
                if (m_first != b) begin
                    m_bits.push_back(m_first);
                    if (m_bits.size() == W) begin
                        for (int i = 0; i < W; i++) nw[i] = m_bits[i];
                        m_bits.delete();
                        have_word = 1;
                    end
                end
            end
        end
        if (pop) void'(m_fifo.pop_front());
        if (have_word) begin
            if (size0 < D || pop) m_fifo.push_back(nw);
            else m_ovf = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic emit_bit(input bit b, input bit rdy);
        step(1, b, rdy, 1, 0);
        step(1, ~b, rdy, 1, 0);
    endtask

    task automatic emit_word(input bit rdy, output logic [W-1:0] w);
        bit b;
        for (int i = 0; i < W; i++) begin
            b    = 1'($urandom_range(0, 1));
            w[i] = b;
            emit_bit(b, rdy);
        end
    endtask

    task automatic do_reset();
        rst = 1;
        bit_valid_i = 0; bit_i = 0; clear_i = 0; word_ready_i = 0; en_i = 0;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (level_o !== '0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level_o); end
        if (word_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", word_valid_o); end
        if (word_o !== '0) begin errors++; $display("FAIL reset_word: got %h expected 0", word_o); end
        if (alarm_o !== 1'b0) begin errors++; $display("FAIL reset_alarm: got %b expected 0", alarm_o); end
        if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow_o); end
    endtask

    task automatic test_zero_word();
        for (int i = 0; i < W; i++) begin
            step(1, 0, 1, 1, 0);
            step(1, 1, 1, 1, 0);
        end
        checks += 3;
        if (word_valid_o !== 1'b1) begin errors++; $display("FAIL zero_valid: got %b expected 1", word_valid_o); end
        if (word_o !== 32'h0000_0000) begin errors++; $display("FAIL zero_word: got %h expected 00000000", word_o); end
        if (level_o !== LW'(1)) begin errors++; $display("FAIL zero_level: got %0d expected 1", level_o); end
        step(0, 0, 1, 1, 0);
        checks += 2;
        if (word_valid_o !== 1'b0) begin errors++; $display("FAIL zero_drain_valid: got %b expected 0", word_valid_o); end
        if (level_o !== '0) begin errors++; $display("FAIL zero_drain_level: got %0d expected 0", level_o); end
    endtask

    task automatic test_alternating();
        for (int i = 0; i < 16; i++) begin
            step(1, 1, 1, 1, 0); step(1, 0, 1, 1, 0);
            step(1, 0, 1, 1, 0); step(1, 1, 1, 1, 0);
        end
        checks += 2;
        if (word_o !== 32'h5555_5555) begin errors++; $display("FAIL alt_word: got %h expected 55555555", word_o); end
        if (word_o !== m_fifo[0]) begin errors++; $display("FAIL alt_model: got %h expected %h", word_o, m_fifo[0]); end
        step(0, 0, 1, 1, 0);
    endtask

    task automatic test_discard();
        for (int i = 0; i < W; i++) begin
            step(1, 1, 1, 1, 0); step(1, 1, 1, 1, 0);
            step(1, 0, 1, 1, 0); step(1, 0, 1, 1, 0);
            if (i == W - 1) begin
                checks++;
                if (level_o !== '0) begin errors++; $display("FAIL discard_early: got %0d expected 0", level_o); end
            end
            step(1, 1, 1, 1, 0); step(1, 0, 1, 1, 0);
        end
        checks += 2;
        if (word_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL discard_word: got %h expected ffffffff", word_o); end
        if (level_o !== LW'(1)) begin errors++; $display("FAIL discard_level: got %0d expected 1", level_o); end
        step(0, 0, 1, 1, 0);
    endtask

    task automatic test_overflow();
        logic [W-1:0] words[5];
        for (int k = 0; k < 5; k++) begin
            emit_word(0, words[k]);
            if (k == 3) begin
                checks += 2;
                if (level_o !== LW'(4)) begin errors++; $display("FAIL ovf_level4: got %0d expected 4", level_o); end
                if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", overflow_o); end
            end
        end
        checks += 2;
        if (level_o !== LW'(4)) begin errors++; $display("FAIL ovf_level: got %0d expected 4", level_o); end
        if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow_o); end
        for (int k = 0; k < 4; k++) begin
            checks += 2;
            if (word_o !== words[k]) begin errors++; $display("FAIL ovf_order%0d: got %h expected %h", k, word_o, words[k]); end
            if (word_valid_o !== 1'b1) begin errors++; $display("FAIL ovf_valid%0d: got %b expected 1", k, word_valid_o); end
            step(0, 0, 1, 1, 0);
        end
        checks += 2;
        if (word_valid_o !== 1'b0) begin errors++; $display("FAIL ovf_fifth: got %b expected 0", word_valid_o); end
        if (level_o !== '0) begin errors++; $display("FAIL ovf_empty: got %0d expected 0", level_o); end
    endtask

    task automatic test_alarm();
        logic [W-1:0] w;
        step(0, 0, 0, 1, 1);
        checks++;
        if (overflow_o !== 1'b0) begin errors++; $display("FAIL clear_ovf: got %b expected 0", overflow_o); end
        for (int i = 0; i < RL - 1; i++) step(1, 1, 0, 1, 0);
        checks++;
        if (alarm_o !== 1'b0) begin errors++; $display("FAIL alarm_early: got %b expected 0", alarm_o); end
        step(1, 1, 0, 1, 0);
        checks++;
        if (alarm_o !== 1'b1) begin errors++; $display("FAIL alarm_set: got %b expected 1", alarm_o); end
        for (int i = 0; i < 40; i++) emit_bit(1'(i), 0);
        checks += 2;
        if (level_o !== LW'(m_fifo.size())) begin errors++; $display("FAIL alarm_nopush: got %0d expected %0d", level_o, m_fifo.size()); end
        if (alarm_o !== 1'b1) begin errors++; $display("FAIL alarm_sticky: got %b expected 1", alarm_o); end
        step(0, 0, 0, 1, 1);
        checks++;
        if (alarm_o !== 1'b0) begin errors++; $display("FAIL alarm_clear: got %b expected 0", alarm_o); end
        emit_word(0, w);
        checks += 2;
        if (level_o !== LW'(1)) begin errors++; $display("FAIL alarm_resume_level: got %0d expected 1", level_o); end
        if (word_o !== w) begin errors++; $display("FAIL alarm_resume_word: got %h expected %h", word_o, w); end
        step(0, 0, 1, 1, 0);
    endtask

    task automatic test_reset_midword();
        logic [W-1:0] w;
        emit_word(0, w);
        emit_word(0, w);
        for (int i = 0; i < 20; i++) emit_bit(1'($urandom_range(0, 1)), 0);
        checks++;
        if (level_o !== LW'(2)) begin errors++; $display("FAIL mid_level2: got %0d expected 2", level_o); end
        do_reset();
        checks += 2;
        if (level_o !== '0) begin errors++; $display("FAIL mid_level: got %0d expected 0", level_o); end
        if (word_valid_o !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", word_valid_o); end
        emit_word(0, w);
        checks += 2;
        if (level_o !== LW'(1)) begin errors++; $display("FAIL mid_fresh_level: got %0d expected 1", level_o); end
        if (word_o !== w) begin errors++; $display("FAIL mid_fresh_word: got %h expected %h", word_o, w); end
        step(0, 0, 1, 1, 0);
    endtask

    task automatic test_en_low();
        logic [W-1:0] w;
        for (int i = 0; i < 10; i++) emit_bit(1'($urandom_range(0, 1)), 1);
        step(1, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 1'(i), 1, 0, 0);
        emit_word(1, w);
        checks += 2;
        if (level_o !== LW'(1)) begin errors++; $display("FAIL en_level: got %0d expected 1", level_o); end
        if (word_o !== w) begin errors++; $display("FAIL en_word: got %h expected %h", word_o, w); end
        step(0, 0, 1, 1, 0);
    endtask

    task automatic test_back_to_back();
        bit v, b, rdy, e, clr;
        for (int c = 0; c < 3000; c++) begin
            v   = ($urandom_range(0, 3) != 0);
            b   = 1'($urandom_range(0, 1));
            rdy = ($urandom_range(0, 2) == 0);
            e   = ($urandom_range(0, 39) != 0);
            clr = ($urandom_range(0, 199) == 0);
            if (c >= 1000 && c < 1040) begin
                v = 1; b = 1; e = 1; clr = 0;
            end
            step(v, b, rdy, e, clr);
            checks += 4;
            if (level_o !== LW'(m_fifo.size())) begin errors++; $display("FAIL rnd_level c=%0d: got %0d expected %0d", c, level_o, m_fifo.size()); end
            if (word_valid_o !== (m_fifo.size() > 0)) begin errors++; $display("FAIL rnd_valid c=%0d: got %b", c, word_valid_o); end
            if (alarm_o !== m_alarm) begin errors++; $display("FAIL rnd_alarm c=%0d: got %b expected %b", c, alarm_o, m_alarm); end
            if (overflow_o !== m_ovf) begin errors++; $display("FAIL rnd_ovf c=%0d: got %b expected %b", c, overflow_o, m_ovf); end
            if (m_fifo.size() > 0) begin
                checks++;
                if (word_o !== m_fifo[0]) begin errors++; $display("FAIL rnd_word c=%0d: got %h expected %h", c, word_o, m_fifo[0]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_word();
        test_alternating();
        test_discard();
        test_overflow();
        test_alarm();
        test_reset_midword();
        test_en_low();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
